fifo_rd_arbiter: RTL and testbench
==================================

# fifo_rd_arbiter

Read-side scheduler that drains up to NUM_PORTS `fifo` instances, sharing one downstream consumer among them. It runs in the read clock domain of the FIFOs and drives each FIFO's `rd_en`. It samples each FIFO's combinational `data_rd` on the pop edge and presents the result as a registered valid/ready stream tagged with the source port. Arbitration is round-robin with a bounded burst per grant.

## Interface
- NUM_PORTS, 4: number of FIFOs served; range 2..16.
- DATA_WIDTH, 8: FIFO data width.
- BURST_MAX, 4: maximum consecutive pops per grant; at least 1.
- rd_clk  in  1  clock; the FIFOs' read clock.
- rst  in  1  reset, asynchronous, active-high.
- fifo_empty  in  NUM_PORTS  `fifo_empty` of each FIFO.
- fifo_data_rd  in  NUM_PORTS*DATA_WIDTH  `data_rd` of each FIFO; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_rd_en  out  NUM_PORTS  `rd_en` to each FIFO; combinational, at most one bit high.
- port_enable  in  NUM_PORTS  per-port service enable; a disabled port is never granted.
- out_data  out  DATA_WIDTH  registered popped word.
- out_port  out  PORT_W  registered source index. PORT_W = max(1, clog2(NUM_PORTS)).
- out_valid  out  1  out_data and out_port are valid.
- out_ready  in  1  consumer accepts the beat.
- grant  out  NUM_PORTS  registered one-hot grant; all zero in IDLE.
- busy  out  1  registered; high in SERVE.

## Operation
- Request vector: req[i] = port_enable[i] & !fifo_empty[i].
- Output slot: a single register. can_load = !out_valid | out_ready.
- State IDLE:
  - When req is nonzero, select the winner by round-robin starting at last_grant+1 (mod NUM_PORTS).
  - Register grant_idx to the winner, set last_grant to the winner, clear burst_cnt, go to SERVE.
  - No pop occurs in IDLE.
- State SERVE, with g = grant_idx:
  - pop = req[g] & can_load; fifo_rd_en[g] = pop.
  - On pop: out_data takes fifo_data_rd[g], out_port takes g, out_valid is set, burst_cnt increments.
  - Go to IDLE when either:
    - pop occurs with burst_cnt == BURST_MAX-1, or
    - req[g] == 0 (granted FIFO empty or disabled), with no pop that cycle.
  - Backpressure (req[g] & !can_load): hold the grant, no pop, burst_cnt unchanged.
- out_valid clears on out_ready & out_valid when no pop occurs in the same cycle. A pop together with a consumer accept is a back-to-back beat, and out_valid stays high.
- burst_cnt width is max(1, clog2(BURST_MAX)). It never exceeds BURST_MAX-1.
- last_grant resets to NUM_PORTS-1, so port 0 has first priority after reset.
- Reset mid-operation: all state clears. A word already popped but not yet accepted is discarded; this loss is accepted by design.

## Timing
- Reset values: fifo_rd_en=0, out_valid=0, out_data=0, out_port=0, grant=0, busy=0, state IDLE.
- Request latency:
  - req rises in cycle 0 while IDLE.
  - Grant and busy are registered at edge 1.
  - First fifo_rd_en is high during cycle 1.
  - out_valid is high from edge 2.
- Throughput: one pop per cycle within a burst while out_ready=1.
- Each grant release costs exactly one IDLE cycle before the next pop.
- Output is stable: out_data and out_port do not change while out_valid & !out_ready.

## Structure
- Package fifo_arb_pkg holds:
  - state enum {IDLE, SERVE};
  - function port_w(n) returning max(1, clog2(n));
  - function rr_pick(req, last) returning the winning index.
- Sub-module fifo_rr_pick is combinational. It rotates req by last+1, finds the lowest set bit, and unrotates to give the winner index and a found flag.
- The top level contains only the FSM, burst counter and output register.

## Test plan
- Reset check: assert rst mid-burst with out_valid=1. All outputs go to 0 immediately; after release, port 0 is granted first if requesting.
- Single port: port 2 holds words 0xA1, 0xA2, 0xA3; out_ready=1; BURST_MAX=4.
  - fifo_rd_en[2] is high for 3 consecutive cycles starting one cycle after the request.
  - Output carries 3 beats with out_port=2.
  - The block returns to IDLE once empty.
- Round-robin: 4 ports with 6 words each, ready=1. Grant order is 0,1,2,3,0,1,2,3 with bursts 4,4,4,4,2,2,2,2. There is exactly one idle cycle between bursts, and all 24 words arrive in per-port order.
- Backpressure: drop out_ready for 5 cycles mid-burst.
  - out_data is held stable, no fifo_rd_en, grant held.
  - After ready returns, the burst completes with its remaining count.
- Disable: deassert port_enable[1] after 2 pops of its burst. No further pop occurs, the next cycle is IDLE, and the next eligible port is granted.
- Skip: port_enable=4'b1010 with all ports full. Only ports 1 and 3 are served, alternating.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO read-side arbiter.
//   state_e  - arbiter FSM states
//   port_w   - index width for n items, never less than one bit
//   rr_pick  - loop formulation of the round-robin choice (up to MaxPorts ports)
package fifo_arb_pkg;

    localparam int unsigned MaxPorts = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    function automatic int unsigned port_w(input int unsigned n);
        return (n <= 2) ? 32'd1 : unsigned'($clog2(n));
    endfunction

    // Winner is the first requester found walking upward from last+1, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [MaxPorts-1:0] req,
                                           input logic [3:0]          last,
                                           input int unsigned         n);
        int unsigned p;
        rr_pick = last;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int unsigned k = n; k >= 1; k--) begin
            p = (32'(last) + k) % n;
            if (req[p]) rr_pick = 4'(p);
        end
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational round-robin winner selection.
//   req_i   - request vector, one bit per port
//   last_i  - index of the most recently granted port
//   idx_o   - winning port index (valid when found_o)
//   found_o - at least one port is requesting
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PORT_W    = port_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    last_i,
    output logic [PORT_W-1:0]    idx_o,
    output logic                 found_o
);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    int unsigned            start;
    logic                   hit;

    always_comb begin
        start   = (32'(last_i) + 32'd1) % NUM_PORTS;
        // Rotate so the highest-priority port lands on bit 0.
        req_dbl = {req_i, req_i} >> start;
        req_rot = req_dbl[NUM_PORTS-1:0];
        hit     = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req_rot[i] && !hit) begin
                hit   = 1'b1;
                idx_o = PORT_W'((i + start) % NUM_PORTS);
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin read scheduler draining several FIFOs into one
// registered valid/ready stream, with a bounded burst per grant.
//   rd_clk, rst   - FIFO read clock; asynchronous active-high reset
//   fifo_empty    - per-FIFO empty flags
//   fifo_data_rd  - per-FIFO combinational read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_rd_en    - per-FIFO pop strobe, at most one high
//   port_enable   - per-port service enable
//   out_data/out_port/out_valid/out_ready - output stream tagged with source port
//   grant         - one-hot current grant, zero when idle
//   busy          - high while serving a grant
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS  = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned BURST_MAX  = 4,
    localparam int unsigned PORT_W     = port_w(NUM_PORTS)
) (
    input  logic                            rd_clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            fifo_empty,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data_rd,
    output logic [NUM_PORTS-1:0]            fifo_rd_en,
    input  logic [NUM_PORTS-1:0]            port_enable,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [PORT_W-1:0]               out_port,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy
);

    localparam int unsigned       CNT_W     = port_w(BURST_MAX);
    localparam logic [CNT_W-1:0]  BurstLast = CNT_W'(BURST_MAX - 1);
    localparam logic [PORT_W-1:0] LastInit  = PORT_W'(NUM_PORTS - 1);

    state_e                  state_q, state_d;
    logic [PORT_W-1:0]       grant_idx_q, grant_idx_d;
    logic [PORT_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]        burst_q, burst_d;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [PORT_W-1:0]       out_port_q;
    logic                    out_valid_q;

    logic [NUM_PORTS-1:0]    req;
    logic                    can_load;
    logic                    req_g;
    logic                    pop;
    logic [PORT_W-1:0]       pick_idx;
    logic                    pick_found;

    assign req      = port_enable & ~fifo_empty;
    assign can_load = !out_valid_q || out_ready;
    assign req_g    = req[grant_idx_q];
    assign pop      = (state_q == SERVE) && req_g && can_load;

    fifo_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        burst_d     = burst_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_d = pick_idx;
                    last_d      = pick_idx;
                    burst_d     = '0;
                    state_d     = SERVE;
                end
            end
            SERVE: begin
                if (pop) begin
                    // Hold the counter on the final beat so it never reaches BURST_MAX.
                    if (burst_q == BurstLast) begin
                        state_d = IDLE;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end else if (!req_g) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_q      <= LastInit;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
        end
    end

    // A pop refills the slot even when the consumer takes the old beat this cycle.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_data_q  <= fifo_data_rd[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
            out_port_q  <= grant_idx_q;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_comb begin
        fifo_rd_en              = '0;
        fifo_rd_en[grant_idx_q] = pop;
    end

    always_comb begin
        grant = '0;
        if (state_q == SERVE) grant[grant_idx_q] = 1'b1;
    end

    assign busy      = (state_q == SERVE);
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int PW = 2;

    logic             rd_clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    fifo_empty;
    logic [NP*DW-1:0] fifo_data_rd;
    logic [NP-1:0]    fifo_rd_en;
    logic [NP-1:0]    port_enable;
    logic [DW-1:0]    out_data;
    logic [PW-1:0]    out_port;
    logic             out_valid;
    logic             out_ready;
    logic [NP-1:0]    grant;
    logic             busy;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .rd_clk       (rd_clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_data_rd (fifo_data_rd),
        .fifo_rd_en   (fifo_rd_en),
        .port_enable  (port_enable),
        .out_data     (out_data),
        .out_port     (out_port),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .grant        (grant),
        .busy         (busy)
    );

    typedef struct {
        int port;
        int len;
    } burst_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] fifo_q [NP][$];   // FIFO contents seen by the DUT
    logic [DW-1:0] exp_q  [NP][$];   // words still expected on the output, per port
    burst_t        exp_burst [$];    // expected (port, pops) per grant, in order
    int            last_m;           // model's most recent grant

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            fifo_empty[i] = (fifo_q[i].size() == 0);
            fifo_data_rd[i*DW +: DW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
        end
    endtask

    // One clock: sample at the falling edge, then apply pops just after the rising edge.
    task automatic step(output logic [NP-1:0] en, output logic bsy, output logic vld);
        @(negedge rd_clk);
        en  = fifo_rd_en;
        bsy = busy;
        vld = out_valid;
        @(posedge rd_clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < NP; i++) begin
                if (en[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
            end
        end
        refresh();
    endtask

    task automatic tick();
        logic [NP-1:0] e;
        logic          b, v;
        step(e, b, v);
    endtask

    task automatic load(input int p, input int n, input logic [DW-1:0] base, input bit rnd);
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = rnd ? DW'($urandom) : base + DW'(k);
            fifo_q[p].push_back(d);
            exp_q[p].push_back(d);
        end
        refresh();
    endtask

    // Transaction-level prediction: round-robin over ports with words, each grant takes
    // min(BURST_MAX, words available). Valid while contents and enables stay fixed.
    task automatic predict(input logic [NP-1:0] mask);
        int cnt [NP];
        int p, pt, len;
        bit hit;
        for (int i = 0; i < NP; i++) cnt[i] = fifo_q[i].size();
        do begin
            hit = 0;
            p   = 0;
            for (int k = 1; k <= NP; k++) begin
                pt = (last_m + k) % NP;
                if (!hit && mask[pt] && cnt[pt] > 0) begin
                    hit = 1;
                    p   = pt;
                end
            end
            if (hit) begin
                len     = (cnt[p] < BM) ? cnt[p] : BM;
                cnt[p] -= len;
                exp_burst.push_back('{port: p, len: len});
                last_m  = p;
            end
        end while (hit);
    endtask

    task automatic drain(input logic [NP-1:0] mask, input bit rnd);
        logic [NP-1:0] en;
        logic          b, v;
        bit            done;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(en, b, v);
            done = (exp_burst.size() == 0) && !b && !v;
            for (int i = 0; i < NP; i++) if (mask[i] && fifo_q[i].size() != 0) done = 0;
        end
        out_ready = 1'b1;
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_port"}, 32'(out_port), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor / scoreboard
    logic          m_prev_stall, m_prev_idle_req, m_active;
    logic [DW-1:0] m_prev_data;
    logic [PW-1:0] m_prev_port;
    logic [NP-1:0] m_prev_grant;
    int            m_gport, m_gpops;

    always @(negedge rd_clk) begin
        burst_t e;
        logic   ok;
        if (rst) begin
            m_prev_stall    = 1'b0;
            m_prev_idle_req = 1'b0;
            m_active        = 1'b0;
        end else begin
            ok = $onehot0(fifo_rd_en) && ((fifo_rd_en & ~grant) == '0)
                 && ((fifo_rd_en & (~port_enable | fifo_empty)) == '0);
            chk("rd_en_legal", 32'(ok), 32'd1);
            ok = busy ? $onehot(grant) : (grant == '0);
            chk("grant_shape", 32'(ok), 32'd1);
            if (m_prev_stall) begin
                chk("out_hold", 32'({out_port, out_data}), 32'({m_prev_port, m_prev_data}));
                chk("out_valid_hold", 32'(out_valid), 32'd1);
            end
            if (out_valid && !out_ready) chk("no_pop_stall", 32'(fifo_rd_en), 32'd0);
            if (m_prev_idle_req) chk("idle_gap", 32'(busy), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q[out_port].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_expected: unexpected beat port %0d data 0x%0h at %0t",
                             out_port, out_data, $time);
                end else begin
                    chk("beat_data", 32'(out_data), 32'(exp_q[out_port].pop_front()));
                end
            end
            if (busy) begin
                if (!m_active) begin
                    m_active     = 1'b1;
                    m_gpops      = 0;
                    m_prev_grant = grant;
                    m_gport      = 0;
                    for (int i = 0; i < NP; i++) if (grant[i]) m_gport = i;
                end else begin
                    chk("grant_held", 32'(grant), 32'(m_prev_grant));
                end
                if (fifo_rd_en != '0) m_gpops++;
            end else if (m_active) begin
                m_active = 1'b0;
                if (exp_burst.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL burst_expected: unexpected grant port %0d pops %0d at %0t",
                             m_gport, m_gpops, $time);
                end else begin
                    e = exp_burst.pop_front();
                    chk("burst_port", 32'(m_gport), 32'(e.port));
                    chk("burst_len", 32'(m_gpops), 32'(e.len));
                end
            end
            m_prev_stall    = out_valid && !out_ready;
            m_prev_data     = out_data;
            m_prev_port     = out_port;
            m_prev_idle_req = !busy && ((port_enable & ~fifo_empty) != '0);
        end
    end

    // Stimulus
    initial begin
        logic [NP-1:0] en;
        logic          b, v;
        logic [NP-1:0] pat_en [6];
        logic          pat_busy [6];
        logic          pat_valid [6];
        logic [NP-1:0] mask;
        int            pops, total;

        rst          = 1'b1;
        port_enable  = '1;
        out_ready    = 1'b1;
        fifo_empty   = '1;
        fifo_data_rd = '0;
        last_m       = NP - 1;
        refresh();
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Round-robin: 6 words per port, bursts of 4 then 2.
        for (int p = 0; p < NP; p++) load(p, 6, '0, 1'b1);
        predict('1);
        drain('1, 1'b0);

        // Single port: cycle-accurate request latency and burst of 3.
        pat_en    = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        pat_busy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        pat_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        load(2, 3, 8'hA1, 1'b0);
        predict('1);
        for (int k = 0; k < 6; k++) begin
            step(en, b, v);
            chk("single_rd_en", 32'(en), 32'(pat_en[k]));
            chk("single_busy", 32'(b), 32'(pat_busy[k]));
            chk("single_valid", 32'(v), 32'(pat_valid[k]));
        end
        drain('1, 1'b0);

        // Backpressure mid-burst.
        load(3, 4, '0, 1'b1);
        predict('1);
        pops = 0;
        for (int c = 0; c < 20 && pops < 2; c++) begin
            step(en, b, v);
            if (en[3]) pops++;
        end
        chk("bp_reach", 32'(pops), 32'd2);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(en, b, v);
            chk("bp_no_pop", 32'(en), 32'd0);
            chk("bp_busy", 32'(b), 32'd1);
        end
        drain('1, 1'b0);

        // Disable the granted port after two pops.
        port_enable = '1;
        load(1, 6, '0, 1'b1);
        exp_burst.push_back('{port: 1, len: 2});
        exp_burst.push_back('{port: 2, len: 3});
        pops = 0;
        for (int c = 0; c < 20 && pops < 2; c++) begin
            step(en, b, v);
            if (en[1]) begin
                pops++;
                if (pops == 1) load(2, 3, '0, 1'b1);
            end
        end
        chk("dis_reach", 32'(pops), 32'd2);
        port_enable[1] = 1'b0;
        last_m = 2;
        drain(4'b1101, 1'b0);
        port_enable = '1;
        predict('1);
        drain('1, 1'b0);

        // Skip disabled ports.
        for (int p = 0; p < NP; p++) load(p, 5, '0, 1'b1);
        port_enable = 4'b1010;
        predict(4'b1010);
        drain(4'b1010, 1'b0);
        port_enable = '1;
        predict('1);
        drain('1, 1'b0);

        // Random fills, enables and consumer stalls.
        for (int it = 0; it < 8; it++) begin
            for (int p = 0; p < NP; p++) load(p, int'($urandom_range(0, 7)), '0, 1'b1);
            mask        = NP'($urandom_range(1, 15));
            port_enable = mask;
            predict(mask);
            drain(mask, 1'b1);
        end
        port_enable = '1;
        predict('1);
        drain('1, 1'b1);

        // Reset mid-burst with a beat pending.
        load(1, 4, '0, 1'b1);
        load(3, 4, '0, 1'b1);
        predict('1);
        v = 1'b0;
        for (int c = 0; c < 10 && !v; c++) step(en, b, v);
        out_ready = 1'b0;
        #2;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        for (int p = 0; p < NP; p++) begin
            fifo_q[p].delete();
            exp_q[p].delete();
        end
        exp_burst.delete();
        last_m = NP - 1;
        refresh();
        load(2, 2, '0, 1'b1);
        load(0, 2, '0, 1'b1);
        predict('1);
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        drain('1, 1'b0);

        total = 0;
        for (int p = 0; p < NP; p++) total += exp_q[p].size();
        chk("all_words_seen", 32'(total), 32'd0);
        chk("all_bursts_seen", 32'(exp_burst.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
